vga_sync_receiver: RTL and testbench
====================================

# vga_sync_receiver

Sink-side counterpart of the VGA sync generator. Takes the H_Sync/V_Sync pair, for example looped back from the display port or produced by a second generator, and samples it on the 100 MHz board clock. From that pair it recovers the pixel-enable phase, the active-area pixel coordinates and the display-enable signal. It also measures line and frame length and runs a lock FSM, so the text/graphics path and the bench can confirm the timing stream is well formed.

## Interface
Parameters:
- H_PERIOD_CLKS, 3200, nominal reloj cycles per line (800 px × 4)
- H_TOL, 8, allowed ± deviation of a measured line, in reloj cycles
- H_BP, 48, pixels from end of hsync pulse to first active pixel
- H_ACTIVE, 640, active pixels per line
- V_LINES, 525, expected lines per frame
- V_BP, 33, lines from end of vsync pulse to first active line
- V_ACTIVE, 480, active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
- reloj  in  1  board clock, 100 MHz
- resetM  in  1  asynchronous, active-high reset
- h_sync_in  in  1  horizontal sync, active-low pulse, asynchronous to reloj
- v_sync_in  in  1  vertical sync, active-low pulse, asynchronous to reloj
- px_en  out  1  one-cycle pixel strobe, every 4th reloj cycle
- px_x  out  10  active-area column 0..H_ACTIVE-1; 0 outside the active area
- px_y  out  10  active-area row 0..V_ACTIVE-1; 0 outside the active area
- de  out  1  high while inside the active area
- line_clks  out  12  reloj cycles between the last two hsync falling edges, saturating at 4095
- frame_lines  out  10  lines counted in the last completed frame
- locked  out  1  timing stream verified
- sync_err  out  1  one-cycle pulse on a bad frame or a timeout

## Operation
- Both sync inputs pass through 2-flop synchronizers, then a registered edge detector giving hs_fall, hs_rise and vs_rise.
- Phase counter (2 bit):
  - cleared on hs_rise;
  - px_en is asserted when the phase counter equals 3.
- Pixel counter x (10 bit):
  - cleared on hs_rise;
  - +1 on each px_en;
  - holds at 1023.
- Line counter y (10 bit):
  - cleared on vs_rise;
  - +1 on each hs_fall;
  - holds at 1023.
- de = (H_BP ≤ x < H_BP+H_ACTIVE) AND (V_BP ≤ y < V_BP+V_ACTIVE).
- When de is high: px_x = x−H_BP and px_y = y−V_BP. Otherwise both are 0.
- Line measurement:
  - 12-bit cycle counter, cleared on hs_fall, saturating;
  - on hs_fall, the pre-clear value is copied into line_clks;
  - the line is "bad" if |value − H_PERIOD_CLKS| > H_TOL;
  - a bad-line sticky flag is cleared on vs_rise.
- Frame length counter (10 bit): counts hs_fall between vs_rise events; on vs_rise it is copied into frame_lines.
- Simultaneous hs_fall and vs_rise in one cycle:
  - the frame evaluation uses the line count before that hs_fall;
  - that hs_fall counts as line 1 of the new frame;
  - its line measurement counts toward the new frame's bad-line flag.
- Lock FSM, states SEARCH, CHECK, LOCKED, with a good-frame counter:
  - SEARCH: on vs_rise → CHECK, good count = 0. Frames before the first vs_rise are never evaluated.
  - CHECK: on vs_rise, the frame is good if frame count == V_LINES and the bad-line flag is clear.
    - Good frame: increment the good count; when it reaches LOCK_FRAMES → LOCKED.
    - Bad frame: good count = 0, sync_err pulse.
  - LOCKED: on vs_rise with a bad frame → CHECK, good count = 0, sync_err pulse.
  - Any state: if the line cycle counter reaches 2×H_PERIOD_CLKS with no hs_fall → SEARCH, sync_err pulse (once per timeout episode).
- locked = (state == LOCKED). Coordinate outputs run regardless of the lock state.

## Timing
- Reset values (asynchronous): all counters 0, state SEARCH, and every output 0 (px_en, px_x, px_y, de, line_clks, frame_lines, locked, sync_err).
- Latency from a raw sync edge to its edge strobe is 3 reloj cycles (2 synchronizer + 1 detect). x/phase clear and y/measurement updates take effect 1 cycle after the strobe.
- de, px_x and px_y are registered and aligned with the cycle in which px_en is asserted.
- locked and sync_err change 1 cycle after the evaluating vs_rise strobe.
- Reset asserted mid-frame: all outputs return to 0 immediately. After release, the block needs a fresh vs_rise plus LOCK_FRAMES good frames before locked rises.

## Test plan
- Nominal stream (3200-clk lines, 384-clk hsync low, 525 lines, 2-line vsync low), starting mid-frame → line_clks = 3200 and frame_lines = 525. locked rises 4 cycles after the 3rd raw vsync rising edge. sync_err never pulses.
- Locked nominal stream, per active line → exactly 640 px_en cycles with de high; px_x runs 0..639. In the first active line px_y = 0; in the last px_y = 479.
- One line stretched to 3209 clks while locked → at the next vs_rise, a single sync_err pulse and locked falls. Relock after 2 good frames. A line of 3208 clks causes no error.
- Frame of 524 lines while locked → sync_err pulse, frame_lines = 524, state CHECK.
- hsync held high for 6400 clks → sync_err pulse once, locked = 0, state SEARCH. Resuming the stream relocks.
- resetM pulsed mid-frame while locked → all outputs 0 at once. locked rises only after a new vs_rise plus 2 good frames.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers pixel phase, active-area coordinates and display enable
// from an asynchronous H_Sync/V_Sync pair. It also measures line and frame length
// and runs a lock FSM that flags malformed timing.
module vga_sync_receiver #(
    parameter int unsigned H_PERIOD_CLKS = 3200,
    parameter int unsigned H_TOL         = 8,
    parameter int unsigned H_BP          = 48,
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned V_LINES       = 525,
    parameter int unsigned V_BP          = 33,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned LOCK_FRAMES   = 2
) (
    input  logic        reloj,
    input  logic        resetM,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    output logic        px_en,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic        de,
    output logic [11:0] line_clks,
    output logic [9:0]  frame_lines,
    output logic        locked,
    output logic        sync_err
);

    // The cycle counter must be able to reach the 2-line timeout, which can exceed
    // the 12-bit range of line_clks; line_clks is a saturated view of it.
    localparam int unsigned TO_W  = $clog2(2 * H_PERIOD_CLKS + 2);
    localparam int unsigned CYC_W = (TO_W > 12) ? TO_W : 12;
    localparam logic [CYC_W-1:0] CYC_TIMEOUT = CYC_W'(2 * H_PERIOD_CLKS);
    localparam logic [CYC_W-1:0] CYC_LO      = CYC_W'(H_PERIOD_CLKS - H_TOL);
    localparam logic [CYC_W-1:0] CYC_HI      = CYC_W'(H_PERIOD_CLKS + H_TOL);
    localparam logic [CYC_W-1:0] CYC_SAT12   = CYC_W'(4095);

    localparam logic [9:0] X_LO      = 10'(H_BP);
    localparam logic [9:0] X_HI      = 10'(H_BP + H_ACTIVE);
    localparam logic [9:0] Y_LO      = 10'(V_BP);
    localparam logic [9:0] Y_HI      = 10'(V_BP + V_ACTIVE);
    localparam logic [9:0] FRAME_LEN = 10'(V_LINES);

    localparam int unsigned GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        StSearch,
        StCheck,
        StLocked
    } state_e;

    // Synchronizers and edge strobes
    logic hs_meta_q, hs_sync_q, hs_dly_q;
    logic vs_meta_q, vs_sync_q, vs_dly_q;
    logic hs_fall_q, hs_fall_d;
    logic hs_rise_q, hs_rise_d;
    logic vs_rise_q, vs_rise_d;

    // Counters and state
    logic [1:0]       phase_q, phase_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [9:0]       frm_cnt_q, frm_cnt_d;
    logic             bad_q, bad_d;
    logic [GOOD_W-1:0] good_q, good_d;
    state_e           state_q, state_d;

    // Registered outputs
    logic             px_en_q, px_en_d;
    logic [9:0]       px_x_q, px_x_d;
    logic [9:0]       px_y_q, px_y_d;
    logic             de_q, de_d;
    logic [11:0]      line_clks_q, line_clks_d;
    logic [9:0]       frame_lines_q, frame_lines_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;

    logic line_bad;
    logic frame_ok;
    logic timeout;

    assign line_bad = (cyc_q < CYC_LO) || (cyc_q > CYC_HI);
    assign frame_ok = (frm_cnt_q == FRAME_LEN) && !bad_q;
    // Fires on the single cycle the counter sits at the limit; it keeps counting
    // past it, so one stalled line gives one pulse.
    assign timeout  = (cyc_q == CYC_TIMEOUT) && !hs_fall_q;

    // Edge detection on the synchronized sync levels
    always_comb begin
        hs_fall_d = hs_dly_q & ~hs_sync_q;
        hs_rise_d = ~hs_dly_q & hs_sync_q;
        vs_rise_d = ~vs_dly_q & vs_sync_q;
    end

    // Pixel phase, coordinates, line measurement and frame bookkeeping
    always_comb begin
        phase_d = hs_rise_q ? 2'd0 : phase_q + 2'd1;

        x_d = x_q;
        if (hs_rise_q) begin
            x_d = '0;
        end else if ((phase_q == 2'd3) && (x_q != 10'h3FF)) begin
            x_d = x_q + 10'd1;
        end

        y_d = y_q;
        if (vs_rise_q) begin
            y_d = hs_fall_q ? 10'd1 : 10'd0;
        end else if (hs_fall_q && (y_q != 10'h3FF)) begin
            y_d = y_q + 10'd1;
        end

        // Outputs are registered from next-state values so they line up with px_en.
        px_en_d = (phase_d == 2'd3);
        de_d    = (x_d >= X_LO) && (x_d < X_HI) && (y_d >= Y_LO) && (y_d < Y_HI);
        px_x_d  = de_d ? (x_d - X_LO) : 10'd0;
        px_y_d  = de_d ? (y_d - Y_LO) : 10'd0;

        // Restart at 1 so the count captured at the next strobe equals the
        // distance between the two falling edges.
        cyc_d = cyc_q;
        if (hs_fall_q) begin
            cyc_d = CYC_W'(1);
        end else if (cyc_q != '1) begin
            cyc_d = cyc_q + CYC_W'(1);
        end

        line_clks_d = line_clks_q;
        if (hs_fall_q) begin
            line_clks_d = (cyc_q > CYC_SAT12) ? 12'hFFF : cyc_q[11:0];
        end

        // A coincident hs_fall belongs to the new frame.
        bad_d         = bad_q | (hs_fall_q & line_bad);
        frm_cnt_d     = frm_cnt_q;
        frame_lines_d = frame_lines_q;
        if (vs_rise_q) begin
            bad_d         = hs_fall_q & line_bad;
            frm_cnt_d     = hs_fall_q ? 10'd1 : 10'd0;
            frame_lines_d = frm_cnt_q;
        end else if (hs_fall_q && (frm_cnt_q != 10'h3FF)) begin
            frm_cnt_d = frm_cnt_q + 10'd1;
        end
    end

    // Lock FSM: next state, good-frame count and error pulse
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        if (timeout) begin
            state_d = StSearch;
            good_d  = '0;
            err_d   = 1'b1;
        end else if (vs_rise_q) begin
            case (state_q)
                StSearch: begin
                    state_d = StCheck;
                    good_d  = '0;
                end
                StCheck: begin
                    if (frame_ok) begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_d == GOOD_TARGET) begin
                            state_d = StLocked;
                        end
                    end else begin
                        good_d = '0;
                        err_d  = 1'b1;
                    end
                end
                StLocked: begin
                    if (!frame_ok) begin
                        state_d = StCheck;
                        good_d  = '0;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = StSearch;
                    good_d  = '0;
                end
            endcase
        end
        locked_d = (state_d == StLocked);
    end

    // Sync chains idle high so reset release does not look like a sync edge
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            hs_meta_q <= 1'b1;
            hs_sync_q <= 1'b1;
            hs_dly_q  <= 1'b1;
            vs_meta_q <= 1'b1;
            vs_sync_q <= 1'b1;
            vs_dly_q  <= 1'b1;
            hs_fall_q <= 1'b0;
            hs_rise_q <= 1'b0;
            vs_rise_q <= 1'b0;
        end else begin
            hs_meta_q <= h_sync_in;
            hs_sync_q <= hs_meta_q;
            hs_dly_q  <= hs_sync_q;
            vs_meta_q <= v_sync_in;
            vs_sync_q <= vs_meta_q;
            vs_dly_q  <= vs_sync_q;
            hs_fall_q <= hs_fall_d;
            hs_rise_q <= hs_rise_d;
            vs_rise_q <= vs_rise_d;
        end
    end

    // Counter, FSM and output registers
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            phase_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            cyc_q         <= '0;
            frm_cnt_q     <= '0;
            bad_q         <= 1'b0;
            good_q        <= '0;
            state_q       <= StSearch;
            px_en_q       <= 1'b0;
            px_x_q        <= '0;
            px_y_q        <= '0;
            de_q          <= 1'b0;
            line_clks_q   <= '0;
            frame_lines_q <= '0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            x_q           <= x_d;
            y_q           <= y_d;
            cyc_q         <= cyc_d;
            frm_cnt_q     <= frm_cnt_d;
            bad_q         <= bad_d;
            good_q        <= good_d;
            state_q       <= state_d;
            px_en_q       <= px_en_d;
            px_x_q        <= px_x_d;
            px_y_q        <= px_y_d;
            de_q          <= de_d;
            line_clks_q   <= line_clks_d;
            frame_lines_q <= frame_lines_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
        end
    end

    assign px_en       = px_en_q;
    assign px_x        = px_x_q;
    assign px_y        = px_y_q;
    assign de          = de_q;
    assign line_clks   = line_clks_q;
    assign frame_lines = frame_lines_q;
    assign locked      = locked_q;
    assign sync_err    = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver. The timing geometry is scaled down
// (200-clk lines, 10-line frames) so many frames fit in a short run; the
// horizontal tolerance is kept at the nominal 8 clocks.
`timescale 1ns/1ps
module tb_vga_sync_receiver;

    localparam int HP      = 200;
    localparam int HT      = 8;
    localparam int HBP     = 4;
    localparam int HACT    = 40;
    localparam int VL      = 10;
    localparam int VBP     = 2;
    localparam int VACT    = 6;
    localparam int LF      = 2;
    localparam int HS_LOW  = 24;
    localparam int VS_LOW  = 2;
    localparam int TO_LEN  = HS_LOW + 2 * HP;
    localparam int BOUND   = 4 * HP * VL;

    logic        reloj = 1'b0;
    logic        resetM;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        px_en;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic        de;
    logic [11:0] line_clks;
    logic [9:0]  frame_lines;
    logic        locked;
    logic        sync_err;

    vga_sync_receiver #(
        .H_PERIOD_CLKS(HP),
        .H_TOL        (HT),
        .H_BP         (HBP),
        .H_ACTIVE     (HACT),
        .V_LINES      (VL),
        .V_BP         (VBP),
        .V_ACTIVE     (VACT),
        .LOCK_FRAMES  (LF)
    ) dut (
        .reloj      (reloj),
        .resetM     (resetM),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .px_en      (px_en),
        .px_x       (px_x),
        .px_y       (px_y),
        .de         (de),
        .line_clks  (line_clks),
        .frame_lines(frame_lines),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 reloj = ~reloj;

    int n_vec = 0;
    int n_bad = 0;

    // Stream generator state
    int gen_h;
    int gen_line;
    int line_len;
    int frame_len;
    int vs_edges = 0;
    int err_cnt  = 0;

    // Active-line monitor
    logic mon_en  = 1'b0;
    logic in_line = 1'b0;
    int cur_cnt, cur_first, cur_last, cur_y;
    int n_rec = 0;
    int rec_cnt[16];
    int rec_first[16];
    int rec_last[16];
    int rec_y[16];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_levels();
        h_sync_in = (gen_h < HS_LOW) ? 1'b0 : 1'b1;
        v_sync_in = (gen_line < VS_LOW) ? 1'b0 : 1'b1;
    endtask

    // One clock: sample outputs just after the edge, then advance the stream.
    task automatic step();
        logic vs_old;
        @(posedge reloj);
        #1;
        if (sync_err) err_cnt++;
        if (mon_en) begin
            if (px_en && de) begin
                if (!in_line) begin
                    in_line   = 1'b1;
                    cur_cnt   = 0;
                    cur_first = int'(px_x);
                    cur_y     = int'(px_y);
                end
                cur_cnt++;
                cur_last = int'(px_x);
            end else if (!de && in_line) begin
                in_line = 1'b0;
                if (n_rec < 16) begin
                    rec_cnt[n_rec]   = cur_cnt;
                    rec_first[n_rec] = cur_first;
                    rec_last[n_rec]  = cur_last;
                    rec_y[n_rec]     = cur_y;
                end
                n_rec++;
            end
        end
        vs_old = v_sync_in;
        gen_h++;
        if (gen_h >= line_len) begin
            gen_h = 0;
            gen_line++;
            if (gen_line >= frame_len) gen_line = 0;
        end
        drive_levels();
        if (!vs_old && v_sync_in) vs_edges++;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int line);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(gen_line == line && gen_h == 0) && n < BOUND);
        if (!(gen_line == line && gen_h == 0)) check_val("run_to_bound", 32'(gen_line), 32'(line));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_px_en"}, 32'(px_en), 0);
        check_val({tag, "_px_x"}, 32'(px_x), 0);
        check_val({tag, "_px_y"}, 32'(px_y), 0);
        check_val({tag, "_de"}, 32'(de), 0);
        check_val({tag, "_line_clks"}, 32'(line_clks), 0);
        check_val({tag, "_frame_lines"}, 32'(frame_lines), 0);
        check_val({tag, "_locked"}, 32'(locked), 0);
        check_val({tag, "_sync_err"}, 32'(sync_err), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        gen_h     = 100;
        gen_line  = 5;
        line_len  = HP;
        frame_len = VL;
        drive_levels();
        resetM = 1'b1;
        repeat (3) @(posedge reloj);
        #1;
        check_outputs_zero("reset");
        resetM = 1'b0;

        // Acquire lock from mid-frame: locked 4 cycles after 3rd raw vsync rise
        n = 0;
        while (vs_edges < 3 && n < BOUND) begin
            step();
            n++;
        end
        if (vs_edges < 3) check_val("wait_vs_bound", 32'(vs_edges), 3);
        step_n(3);
        check_val("lock_cycle3", 32'(locked), 0);
        step();
        check_val("lock_cycle4", 32'(locked), 1);
        run_to(3);
        check_val("nominal_line_clks", 32'(line_clks), 32'(HP));
        check_val("nominal_frame_lines", 32'(frame_lines), 32'(VL));
        check_val("nominal_no_err", 32'(err_cnt), 0);

        // Active-area geometry over one full frame
        run_to(0);
        n_rec   = 0;
        in_line = 1'b0;
        mon_en  = 1'b1;
        run_to(0);
        mon_en = 1'b0;
        check_val("active_lines", 32'(n_rec), 32'(VACT));
        for (int i = 0; i < VACT; i++) begin
            check_val($sformatf("line%0d_px_count", i), 32'(rec_cnt[i]), 32'(HACT));
            check_val($sformatf("line%0d_first_x", i), 32'(rec_first[i]), 0);
            check_val($sformatf("line%0d_last_x", i), 32'(rec_last[i]), 32'(HACT - 1));
            check_val($sformatf("line%0d_px_y", i), 32'(rec_y[i]), 32'(i));
        end

        // One line 9 clks long: one error at the next vsync, then relock
        run_to(5);
        line_len = HP + 9;
        run_to(6);
        line_len = HP;
        step_n(5);
        check_val("stretch9_line_clks", 32'(line_clks), 32'(HP + 9));
        err_cnt = 0;
        run_to(3);
        check_val("stretch9_err", 32'(err_cnt), 1);
        check_val("stretch9_unlocked", 32'(locked), 0);
        run_to(3);
        check_val("stretch9_relock1", 32'(locked), 0);
        run_to(3);
        check_val("stretch9_relock2", 32'(locked), 1);

        // Line 8 clks long is inside tolerance
        run_to(5);
        line_len = HP + 8;
        run_to(6);
        line_len = HP;
        step_n(5);
        check_val("stretch8_line_clks", 32'(line_clks), 32'(HP + 8));
        err_cnt = 0;
        run_to(3);
        check_val("stretch8_no_err", 32'(err_cnt), 0);
        check_val("stretch8_locked", 32'(locked), 1);

        // Short frame: error, frame_lines shows it, relock from CHECK in 2 frames
        run_to(3);
        frame_len = VL - 1;
        run_to(0);
        frame_len = VL;
        err_cnt = 0;
        run_to(3);
        check_val("short_err", 32'(err_cnt), 1);
        check_val("short_frame_lines", 32'(frame_lines), 32'(VL - 1));
        check_val("short_unlocked", 32'(locked), 0);
        run_to(3);
        check_val("short_relock1", 32'(locked), 0);
        run_to(3);
        check_val("short_relock2", 32'(locked), 1);

        // hsync held high 2 lines: single timeout error, back to SEARCH
        run_to(4);
        err_cnt  = 0;
        line_len = TO_LEN;
        run_to(5);
        line_len = HP;
        step_n(5);
        check_val("timeout_err", 32'(err_cnt), 1);
        check_val("timeout_unlocked", 32'(locked), 0);
        run_to(3);
        check_val("timeout_err_once", 32'(err_cnt), 1);
        check_val("timeout_search_vs", 32'(locked), 0);
        run_to(3);
        check_val("timeout_relock1", 32'(locked), 0);
        run_to(3);
        check_val("timeout_relock2", 32'(locked), 1);

        // Asynchronous reset mid-frame while locked
        run_to(5);
        step_n(100);
        resetM = 1'b1;
        #2;
        check_outputs_zero("midreset");
        step_n(3);
        resetM  = 1'b0;
        err_cnt = 0;
        run_to(3);
        check_val("midreset_vs1", 32'(locked), 0);
        run_to(3);
        check_val("midreset_vs2", 32'(locked), 0);
        run_to(3);
        check_val("midreset_vs3", 32'(locked), 1);
        check_val("midreset_no_err", 32'(err_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
